ifetch_buf: RTL

Instruction prefetch buffer between the DLX core's instruction port (`i_address`, `i_data_read`, `i_data_valid`) and a variable-latency instruction ROM with a req/ack handshake. It fetches consecutive words ahead of the PC into a small FIFO and answers the core in the same cycle on a head hit. On a non-sequential PC it flushes and redirects the fetch stream.

---
 rtl/ifetch_buf.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ifetch_buf.sv
// Instruction prefetch FIFO between the core fetch port and a req/ack ROM.
// Define IFB_STATS_EN to add hit_count / miss_count ports.
module ifetch_buf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  output logic [31:0] i_data_read,
  output logic        i_data_valid,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data
`ifdef IFB_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e          st_q, st_d;
  logic [29:0]     head_q, head_d;
  logic [29:0]     fetch_q, fetch_d;
  logic [29:0]     addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic            drop_q, drop_d;
  logic [31:0]     mem_q [DEPTH];

  logic [29:0]     pc_w, k;
  logic [CW-1:0]   pop;
  logic [AW-1:0]   wp;
  logic            hit, adv, redir, push;
  logic            unused_ok;

  assign pc_w      = i_address[31:2];
  assign unused_ok = ^i_address[1:0];

  always_comb begin
    k     = pc_w - head_q;
    hit   = (k == '0) && (cnt_q != '0);
    adv   = (k != '0) && (k <= 30'(cnt_q));
    redir = (k != '0) && !adv;
    pop   = adv ? k[CW-1:0] : '0;
    push  = (st_q == REQ) && rom_ack && !drop_q && !redir;
    wp    = rp_q + cnt_q[AW-1:0];
  end

  always_comb begin
    head_d  = head_q + 30'(pop);
    rp_d    = rp_q + pop[AW-1:0];
    cnt_d   = cnt_q - pop + CW'(push);
    fetch_d = push ? fetch_q + 30'd1 : fetch_q;
    st_d    = st_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    if (redir) begin
      head_d  = pc_w;
      fetch_d = pc_w;
      cnt_d   = '0;
    end
    unique case (st_q)
      IDLE: begin
        if (cnt_d < CW'(DEPTH)) begin
          st_d   = REQ;
          addr_d = fetch_d;
        end
      end
      REQ: begin
        if (rom_ack) begin
          drop_d = 1'b0;
          // An ack that was already marked stale pauses one cycle in IDLE.
          if (cnt_d < CW'(DEPTH) && !drop_q) addr_d = fetch_d;
          else st_d = IDLE;
        end else if (redir) begin
          drop_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      head_q  <= '0;
      fetch_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rp_q    <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      st_q    <= st_d;
      head_q  <= head_d;
      fetch_q <= fetch_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rp_q    <= rp_d;
      drop_q  <= drop_d;
      if (push) mem_q[wp] <= rom_data;
    end
  end

  assign i_data_read  = mem_q[rp_q];
  assign i_data_valid = hit;
  assign rom_req      = (st_q == REQ);
  assign rom_addr     = {addr_q, 2'b00};

`ifdef IFB_STATS_EN
  logic        hv_q;
  logic [31:0] hcnt_q, mcnt_q;

  // A consumed instruction: valid last cycle, PC moved on in range now.
  always_ff @(posedge clk) begin
    if (reset) begin
      hv_q   <= 1'b0;
      hcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      hv_q <= hit;
      if (adv && hv_q) hcnt_q <= hcnt_q + 32'd1;
      if (redir) mcnt_q <= mcnt_q + 32'd1;
    end
  end

  assign hit_count  = hcnt_q;
  assign miss_count = mcnt_q;
`endif

endmodule
